// File: rtl/dm_ndmreset_ctrl_pkg.sv
// Shared debug definitions for the non-debug-module reset controller: state encoding,
// default hold/release lengths and the counter sizing helper.
package dm_ndmreset_ctrl_pkg;

  typedef enum logic [1:0] {
    NDMRST_IDLE    = 2'd0,
    NDMRST_ASSERT  = 2'd1,
    NDMRST_RELEASE = 2'd2
  } ndmrst_state_e;

  localparam int unsigned DM_RST_HOLD_CYCLES_DEFAULT    = 16;
  localparam int unsigned DM_RST_RELEASE_CYCLES_DEFAULT = 4;

  // One counter serves both phases, so it is sized for the longer of the two.
  function automatic int unsigned ndmrst_cnt_width(input int unsigned hold,
                                                   input int unsigned rel);
    int unsigned longest;
    longest = (hold > rel) ? hold : rel;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/dm_ndmreset_ctrl.sv
// Stretches the DM ndmreset request into a registered, glitch-free system reset, 1-cycle latency.
// No backpressure: a held request extends the hold, a request during release restarts it.
module dm_ndmreset_ctrl
  import dm_ndmreset_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES    = DM_RST_HOLD_CYCLES_DEFAULT,
  parameter int unsigned RST_RELEASE_CYCLES = DM_RST_RELEASE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic testmode_i,
  input  logic ndmreset_i,
  input  logic dmactive_i,
  input  logic ackhavereset_i,
  output logic sys_rst_no,
  output logic rst_busy_o,
  output logic havereset_o
);

  localparam int unsigned CW = ndmrst_cnt_width(RST_HOLD_CYCLES, RST_RELEASE_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  =
    CW'((RST_RELEASE_CYCLES == 0) ? 0 : (RST_RELEASE_CYCLES - 1));
  localparam bit REL_EN = (RST_RELEASE_CYCLES != 0);

  ndmrst_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sys_rst_q, sys_rst_d;
  logic          busy_q, busy_d;
  logic          havereset_q, havereset_d;
  logic          req;
  logic          ack;

  assign req = ndmreset_i & dmactive_i;
  assign ack = ackhavereset_i & dmactive_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= NDMRST_ASSERT;
      cnt_q       <= '0;
      sys_rst_q   <= 1'b0;
      busy_q      <= 1'b1;
      havereset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_rst_q   <= sys_rst_d;
      busy_q      <= busy_d;
      havereset_q <= havereset_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      NDMRST_IDLE: begin
        if (req) begin
          state_d = NDMRST_ASSERT;
          cnt_d   = '0;
        end
      end
      NDMRST_ASSERT: begin
        // Counter saturates at the last hold cycle; a held request parks it there.
        if (cnt_q == HOLD_LAST) begin
          if (!req) begin
            state_d = REL_EN ? NDMRST_RELEASE : NDMRST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      NDMRST_RELEASE: begin
        if (req) begin
          state_d = NDMRST_ASSERT;
          cnt_d   = '0;
        end else if (!REL_EN || (cnt_q == REL_LAST)) begin
          state_d = NDMRST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = NDMRST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the flops present them with 1-cycle latency.
  always_comb begin
    sys_rst_d   = (state_d != NDMRST_ASSERT);
    busy_d      = (state_d != NDMRST_IDLE);
    havereset_d = (state_d == NDMRST_ASSERT) |
                  (havereset_q & ~(ack & (state_q != NDMRST_ASSERT)));
  end

  // DFT bypass: scan reset drives the system reset tree directly.
  assign sys_rst_no  = testmode_i ? rst_ni : sys_rst_q;
  assign rst_busy_o  = busy_q;
  assign havereset_o = havereset_q;

endmodule

// File: doc/dm_ndmreset_ctrl.md
# dm_ndmreset_ctrl

System-side reset controller at the receiving end of the debug module's system signals. Consumes the DM's `ndmreset` request and `dmactive` status and produces a stretched, glitch-free system reset for the harts and peripherals. Reports a sticky `havereset` status back to the DM and a busy flag for `dmstatus` reporting. Sits between the DM and the SoC reset tree, in the DM clock domain.

## Interface
- `RST_HOLD_CYCLES`, 16, minimum low width of `sys_rst_no` in cycles; must be ≥1.
- `RST_RELEASE_CYCLES`, 4, settle cycles after release before returning to idle; may be 0.
- `clk_i` input 1: DM/system clock; the only clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `testmode_i` input 1: DFT bypass; `sys_rst_no` follows `rst_ni` directly.
- `ndmreset_i` input 1: non-debug-module reset request from the DM (level).
- `dmactive_i` input 1: DM active; when 0, `ndmreset_i` and `ackhavereset_i` are ignored.
- `ackhavereset_i` input 1: single-cycle pulse from the DM that clears `havereset_o`.
- `sys_rst_no` output 1: system reset, active-low, registered (except in testmode).
- `rst_busy_o` output 1: high while in ASSERT or RELEASE.
- `havereset_o` output 1: sticky flag; the system has been reset since the last acknowledge.

## Operation
- FSM with states IDLE, ASSERT, RELEASE. Counter `cnt` has width `$clog2(max(HOLD,RELEASE)+1)`. `req = ndmreset_i & dmactive_i`.
- Reset values: state = ASSERT, `cnt` = 0, `sys_rst_no` = 0, `rst_busy_o` = 1, `havereset_o` = 1. Power-on therefore runs a full hold/release sequence.
- IDLE: `sys_rst_no` = 1, busy = 0. If `req`, go to ASSERT with `cnt` = 0.
- ASSERT: `sys_rst_no` = 0, busy = 1. `cnt` increments and saturates at `RST_HOLD_CYCLES-1`.
  - When `cnt` == `HOLD-1` and `!req`: go to RELEASE with `cnt` = 0.
  - A held `req` extends ASSERT indefinitely.
- RELEASE: `sys_rst_no` = 1, busy = 1.
  - If `req`, return to ASSERT with `cnt` = 0.
  - Else if `RST_RELEASE_CYCLES` == 0 or `cnt` == `RELEASE-1`, go to IDLE.
  - Otherwise `cnt` increments.
- `havereset_o` is set on every cycle the state is ASSERT. It is cleared by `ackhavereset_i & dmactive_i` only when the state is not ASSERT. When set and clear coincide, set wins.
- Async reset mid-sequence restarts at reset values. There is no partial state.
- `testmode_i` = 1: `sys_rst_no` = `rst_ni` combinationally. The FSM keeps running but its output is masked.

## Timing
- `req` sampled high at edge N (from IDLE): `sys_rst_no` low after edge N. This is 1-cycle latency.
- Minimum low pulse is exactly `RST_HOLD_CYCLES` cycles. A `req` dropped earlier still gets the full hold.
- `sys_rst_no` rises at the edge after `cnt` reaches `HOLD-1` with `!req`. `rst_busy_o` falls `RST_RELEASE_CYCLES` cycles later (same edge when 0).
- `havereset_o` rises on the edge entering ASSERT. `ackhavereset_i` clears it on the following edge.
- `sys_rst_no` and `rst_busy_o` are driven from flops; no combinational path from inputs, except the testmode mux.

## Structure
- Shared debug package holds the `ndmrst_state_e` enum (IDLE, ASSERT, RELEASE) and the default hold/release constants.
- Single module with no sub-module. The testmode mux is a plain assign at the output, marked as DFT.

## Test plan
- Power-on: release `rst_ni`, all else 0.
  - Expect `sys_rst_no` = 0 for 16 cycles, then 1.
  - Expect `rst_busy_o` to fall 4 cycles later; `havereset_o` = 1.
- Short request: `dmactive_i` = 1, pulse `ndmreset_i` for 1 cycle from IDLE.
  - Expect `sys_rst_no` low exactly 16 cycles, then busy low after 4 more.
- Long request: hold `ndmreset_i` for 40 cycles.
  - Expect `sys_rst_no` low for 40 cycles, rising on the edge after `ndmreset_i` falls.
- Re-request in RELEASE: assert `ndmreset_i` 2 cycles into RELEASE.
  - Expect `sys_rst_no` to drop again next cycle, with a fresh 16-cycle hold.
- Acknowledge:
  - `ackhavereset_i` in IDLE clears `havereset_o` next cycle.
  - Ack during ASSERT leaves it set.
  - Ack with `dmactive_i` = 0 is ignored.
  - `ndmreset_i` with `dmactive_i` = 0 causes no reset.
- Testmode and mid-sequence reset:
  - `testmode_i` = 1: `sys_rst_no` tracks `rst_ni` toggles in the same cycle.
  - `rst_ni` asserted mid-RELEASE: immediate return to reset values.
